// File: rtl/spi_slave_fl.sv
// SPI flash responder: oversamples sclk/ss/mosi on clk, decodes a small flash
// command set and maps READ/PP onto a 32-bit memory port.
module spi_slave_fl #(
    parameter logic [31:0] DEVICE_ID   = 32'h00EF4018,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    output logic        wel
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, RD_REQ, RD_CAP, RESP, IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   ss_prev;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ss_rise;
    logic                   ss_fall;
    logic [4:0]             bit_cnt;
    logic [6:0]             cmd_sr;
    logic [22:0]            addr_sr;
    logic                   is_read;
    logic [31:0]            tx_shift;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev & ~ss_s;
    assign sclk_fall = ~sclk_s &  sclk_prev & ~ss_s;
    assign ss_rise   =  ss_s & ~ss_prev;
    assign ss_fall   = ~ss_s &  ss_prev;

    // ss synchronizer resets low: a frame cut by reset is not re-entered
    // until ss goes high and falls again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '1;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b1;
            ss_prev   <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            addr_sr   <= '0;
            is_read   <= 1'b0;
            tx_shift  <= '0;
            miso      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            wel       <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;

            if (ss_rise) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                tx_shift <= '0;
                miso     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                            miso    <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr  <= {cmd_sr[5:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case ({cmd_sr, mosi_s})
                                    8'h06: begin wel <= 1'b1; state <= IGNORE; end
                                    8'h04: begin wel <= 1'b0; state <= IGNORE; end
                                    8'h05: begin
                                        tx_shift <= {24'b0, 6'b0, wel, 1'b0};
                                        state    <= RESP;
                                    end
                                    8'h9F: begin
                                        tx_shift <= DEVICE_ID;
                                        state    <= RESP;
                                    end
                                    8'h03: begin is_read <= 1'b1; state <= ADDR; end
                                    8'h02: begin is_read <= 1'b0; state <= ADDR; end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr_sr <= {addr_sr[21:0], mosi_s};
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt  <= '0;
                                mem_addr <= {addr_sr, mosi_s};
                                if (is_read) begin
                                    mem_rd <= 1'b1;
                                    state  <= RD_REQ;
                                end else begin
                                    state  <= WDATA;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            mem_wdata <= {mem_wdata[30:0], mosi_s};
                            bit_cnt   <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
                                bit_cnt <= '0;
                                if (wel) begin
                                    mem_wr <= 1'b1;
                                    wel    <= 1'b0;
                                end
                                state <= IGNORE;
                            end
                        end
                    end
                    RD_REQ: state <= RD_CAP;
                    RD_CAP: begin
                        tx_shift <= mem_rdata;
                        state    <= RESP;
                    end
                    RESP: begin
                        if (sclk_fall) begin
                            miso     <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[31:1]};
                        end
                    end
                    IGNORE: miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_fl.sv
// Directed bench for spi_slave_fl: table of SPI frames plus hand-written
// abort and mid-frame reset sequences.
module tb_spi_slave_fl;

    localparam int HALF = 6;
    localparam int NV   = 11;
    localparam logic [31:0] ID = 32'h00EF4018;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        wel;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;

    typedef struct {
        logic [63:0] tx;
        int          nbits;
        int          rx_lsb;
        int          rx_len;
        logic [31:0] exp_rx;
        int          exp_wr;
        int          exp_rd;
        logic        exp_wel;
        logic        chk_mem;
        logic [23:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [NV];

    spi_slave_fl #(.DEVICE_ID(ID), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata), .wel(wel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memory: data appears the clk after mem_rd, keyed on address.
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= (mem_addr == 24'h000010) ? 32'hCAFEF00D : 32'h0BADBAD0;
        if (mem_wr) wr_cnt <= wr_cnt + 1;
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic ss_low();
        ss = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_high();
        ss = 1'b1;
        repeat (2 * HALF + 4) @(negedge clk);
    endtask

    task automatic clock_bits(input logic [63:0] tx, input int n, output logic [63:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            mosi = tx[63-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx[i] = miso;
            repeat (HALF) @(negedge clk);
        end
        mosi = 1'b0;
    endtask

    task automatic xfer(input logic [63:0] tx, input int n, output logic [63:0] rx);
        ss_low();
        clock_bits(tx, n, rx);
        ss_high();
    endtask

    function automatic logic [31:0] field(input logic [63:0] rx, input int lsb, input int len);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < len; j++) w[j] = rx[lsb+j];
        return w;
    endfunction

    logic [63:0] rx;
    int          wr0;
    int          rd0;

    initial begin
        vecs[0]  = '{64'h9F00_0000_0000_0000, 40,  8, 32, ID,           0, 0, 1'b0, 1'b0, 24'h0, 32'h0};
        vecs[1]  = '{64'h9F00_0000_0000_0000, 48, 40,  8, 32'h0,        0, 0, 1'b0, 1'b0, 24'h0, 32'h0};
        vecs[2]  = '{64'h0600_0000_0000_0000,  8,  0,  0, 32'h0,        0, 0, 1'b1, 1'b0, 24'h0, 32'h0};
        vecs[3]  = '{64'h0500_0000_0000_0000, 16,  8,  8, 32'h02,       0, 0, 1'b1, 1'b0, 24'h0, 32'h0};
        vecs[4]  = '{64'h0400_0000_0000_0000,  8,  0,  0, 32'h0,        0, 0, 1'b0, 1'b0, 24'h0, 32'h0};
        vecs[5]  = '{64'h0500_0000_0000_0000, 16,  8,  8, 32'h00,       0, 0, 1'b0, 1'b0, 24'h0, 32'h0};
        vecs[6]  = '{64'h0600_0000_0000_0000,  8,  0,  0, 32'h0,        0, 0, 1'b1, 1'b0, 24'h0, 32'h0};
        vecs[7]  = '{64'h0200_0010_DEAD_BEEF, 64,  0,  0, 32'h0,        1, 0, 1'b0, 1'b1, 24'h000010, 32'hDEADBEEF};
        vecs[8]  = '{64'h0200_0020_1234_5678, 64,  0,  0, 32'h0,        0, 0, 1'b0, 1'b1, 24'h000020, 32'h12345678};
        vecs[9]  = '{64'h0300_0010_0000_0000, 64, 32, 32, 32'hCAFEF00D, 0, 1, 1'b0, 1'b1, 24'h000010, 32'h12345678};
        vecs[10] = '{64'hAB00_0000_0000_0000, 16,  0, 16, 32'h0,        0, 0, 1'b0, 1'b0, 24'h0, 32'h0};

        rst = 1'b1; sclk = 1'b1; ss = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", {63'b0, miso}, 64'd0);
        chk("rst_addr", {40'b0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'b0, mem_wdata}, 64'd0);
        chk("rst_strobes", {62'b0, mem_rd, mem_wr}, 64'd0);
        chk("rst_wel", {63'b0, wel}, 64'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            xfer(vecs[k].tx, vecs[k].nbits, rx);
            if (vecs[k].rx_len > 0)
                chk($sformatf("v%0d_rx", k), {32'b0, field(rx, vecs[k].rx_lsb, vecs[k].rx_len)},
                    {32'b0, vecs[k].exp_rx});
            chk($sformatf("v%0d_wr", k), 64'(wr_cnt - wr0), 64'(vecs[k].exp_wr));
            chk($sformatf("v%0d_rd", k), 64'(rd_cnt - rd0), 64'(vecs[k].exp_rd));
            chk($sformatf("v%0d_wel", k), {63'b0, wel}, {63'b0, vecs[k].exp_wel});
            if (vecs[k].chk_mem) begin
                chk($sformatf("v%0d_addr", k), {40'b0, mem_addr}, {40'b0, vecs[k].exp_addr});
                chk($sformatf("v%0d_wdata", k), {32'b0, mem_wdata}, {32'b0, vecs[k].exp_wdata});
            end
        end

        // PP cut after 12 data bits: no write, wel retained, next RDID intact.
        xfer(64'h0600_0000_0000_0000, 8, rx);
        wr0 = wr_cnt;
        ss_low();
        clock_bits(64'h0200_0030_ABCD_1234, 44, rx);
        ss_high();
        chk("abort_wr", 64'(wr_cnt - wr0), 64'd0);
        chk("abort_wel", {63'b0, wel}, 64'd1);
        xfer(64'h9F00_0000_0000_0000, 40, rx);
        chk("abort_rdid", {32'b0, field(rx, 8, 32)}, {32'b0, ID});

        // Async reset in the middle of an RDID response.
        ss_low();
        clock_bits(64'h9F00_0000_0000_0000, 12, rx);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_miso", {63'b0, miso}, 64'd0);
        chk("mrst_wel", {63'b0, wel}, 64'd0);
        chk("mrst_addr", {40'b0, mem_addr}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clock_bits(64'h9F00_0000_0000_0000, 32, rx);
        chk("mrst_rest", rx, 64'd0);
        ss_high();
        xfer(64'h9F00_0000_0000_0000, 40, rx);
        chk("mrst_rdid", {32'b0, field(rx, 8, 32)}, {32'b0, ID});

        chk("rd_wr_overlap", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
